// File: rtl/axi_lite_master.sv
// axi_lite_master: bridges a held read/write request port to a single-beat AXI4-Lite master.
// Define AXI_CTRL_ERR_EN to add a registered err output flagging a non-OKAY response.
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   store,
    input  logic                done,
    output logic                ready,
    output logic [DATA_W-1:0]   load,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
`ifdef AXI_CTRL_ERR_EN
    ,
    output logic                err
`endif
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP, DONE} state_t;
    state_t state;
    logic aw_ok, w_ok;

    assign wstrb = '1;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            ready   <= 1'b0;
            load    <= '0;
            awaddr  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            araddr  <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_ok <= 1'b0;
                    w_ok  <= 1'b0;
                    if (read) begin
                        state   <= RADDR;
                        araddr  <= addr;
                        arvalid <= 1'b1;
                    end else if (write) begin
                        state   <= WADDR;
                        awaddr  <= addr;
                        wdata   <= store;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end
                end
                RADDR: if (arready) begin
                    state   <= RDATA;
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                end
                RDATA: if (rvalid) begin
                    state  <= DONE;
                    load   <= rdata;
                    rready <= 1'b0;
                    ready  <= 1'b1;
                end
                WADDR: begin
                    // each valid is high exactly while its channel is still unaccepted
                    awvalid <= awvalid & ~awready;
                    wvalid  <= wvalid & ~wready;
                    aw_ok   <= aw_ok | awready;
                    w_ok    <= w_ok | wready;
                    if ((aw_ok | awready) && (w_ok | wready)) begin
                        state  <= WRESP;
                        bready <= 1'b1;
                    end
                end
                WRESP: if (bvalid) begin
                    state  <= DONE;
                    bready <= 1'b0;
                    ready  <= 1'b1;
                end
                DONE: if (done) begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (!nrst) err <= 1'b0;
        else if (state == RDATA && rvalid) err <= rresp != 2'b00;
        else if (state == WRESP && bvalid) err <= bresp != 2'b00;
        else if (state == DONE && done) err <= 1'b0;
    end
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
`endif
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed + random transactions against a delay-configurable AXI-Lite slave and a memory reference model.
module tb_axi_lite_master;
    logic        clk = 1'b0, nrst = 1'b0, read = 1'b0, write = 1'b0, done = 1'b0;
    logic [31:0] addr = '0, store = '0;
    logic        ready, awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] load, awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;
`ifdef AXI_CTRL_ERR_EN
    logic        err;
`endif

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .nrst(nrst), .read(read), .write(write), .addr(addr), .store(store),
        .done(done), .ready(ready), .load(load),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef AXI_CTRL_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, proto_err = 0;
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
    bit r_busy = 0, b_busy = 0, aw_seen = 0, w_seen = 0;
    bit p_arv = 0, p_awv = 0, p_wv = 0;
    logic [31:0] p_ara, p_awa, p_wd, r_addr, wa, wd;
    logic [3:0]  last_wstrb;
    logic [1:0]  r_resp_val = 2'b00, b_resp_val = 2'b00;
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Slave: decides its handshake outputs on the falling edge for the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!nrst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                r_busy = 0; b_busy = 0; aw_seen = 0; w_seen = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                p_arv = 0; p_awv = 0; p_wv = 0;
            end else begin
                if (p_arv && !arready && (!arvalid || araddr !== p_ara)) proto_err++;
                if (p_awv && !awready && (!awvalid || awaddr !== p_awa)) proto_err++;
                if (p_wv && !wready && (!wvalid || wdata !== p_wd)) proto_err++;
                if (bready && (n_aw == 0 || n_w == 0)) proto_err++;
                p_arv = arvalid; p_ara = araddr;
                p_awv = awvalid; p_awa = awaddr;
                p_wv = wvalid; p_wd = wdata;
                if (r_busy) begin
                    if (r_cnt >= r_dly) begin
                        rvalid = 1; rdata = slv_rd(r_addr); rresp = r_resp_val;
                    end else begin
                        r_cnt++; rvalid = 0; rdata = $urandom;
                    end
                end else rvalid = 0;
                if (rvalid && rready) begin r_busy = 0; n_r++; end
                arready = arvalid && ar_cnt >= ar_dly;
                if (arvalid && !arready) ar_cnt++;
                if (arvalid && arready) begin
                    ar_cnt = 0; r_busy = 1; r_cnt = 0; r_addr = araddr; n_ar++;
                end
                if (aw_seen && w_seen) begin
                    slv_mem[wa] = wd; b_busy = 1; b_cnt = 0; aw_seen = 0; w_seen = 0;
                end
                if (b_busy) begin
                    if (b_cnt >= b_dly) begin
                        bvalid = 1; bresp = b_resp_val;
                    end else begin
                        b_cnt++; bvalid = 0;
                    end
                end else bvalid = 0;
                if (bvalid && bready) begin b_busy = 0; n_b++; end
                awready = awvalid && aw_cnt >= aw_dly;
                if (awvalid && !awready) aw_cnt++;
                if (awvalid && awready) begin aw_cnt = 0; wa = awaddr; aw_seen = 1; n_aw++; end
                wready = wvalid && w_cnt >= w_dly;
                if (wvalid && !wready) w_cnt++;
                if (wvalid && wready) begin
                    w_cnt = 0; wd = wdata; last_wstrb = wstrb; w_seen = 1; n_w++;
                end
            end
        end
    end

    task automatic xact(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat);
        int cyc;
        logic [31:0] exp_load;
        n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
        read = rd; write = wr; addr = a; store = d;
        cyc = 0;
        do begin step(); cyc++; end while (!ready && cyc < 200);
        chk("ready_timeout", ready, 1);
        if (exp_lat > 0) chk("latency", cyc, exp_lat);
        exp_load = ref_rd(a);
        if (rd) begin
            chk("load", load, exp_load);
            chk("ar_count", n_ar, 1);
            chk("r_count", n_r, 1);
            chk("araddr", r_addr, a);
            chk("no_write_chan", n_aw + n_w + n_b, 0);
        end else begin
            ref_mem[a] = d;
            chk("aw_count", n_aw, 1);
            chk("w_count", n_w, 1);
            chk("b_count", n_b, 1);
            chk("awaddr", wa, a);
            chk("wdata", wd, d);
            chk("wstrb", last_wstrb, 4'hF);
            chk("no_read_chan", n_ar, 0);
        end
`ifdef AXI_CTRL_ERR_EN
        chk("err_set", err, rd ? (r_resp_val != 2'b00) : (b_resp_val != 2'b00));
`endif
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("ready_hold", ready, 1);
            if (rd) chk("load_hold", load, exp_load);
        end
        done = 1; read = 0; write = 0;
        step();
        done = 0;
        chk("ready_after_done", ready, 0);
        chk("idle_valids", {arvalid, awvalid, wvalid}, 0);
`ifdef AXI_CTRL_ERR_EN
        chk("err_clear", err, 0);
`endif
    endtask

    initial begin
        logic [31:0] b2b [3];
        int cyc;
        b2b = '{32'h0080_167C, 32'h0080_112C, 32'h0080_0140};
        nrst = 0;
        repeat (20) step();
        chk("rst_ready", ready, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 0);
        chk("rst_load", load, 0);
        chk("rst_addr", {araddr, awaddr}, 0);
        chk("rst_wdata", wdata, 0);
`ifdef AXI_CTRL_ERR_EN
        chk("rst_err", err, 0);
`endif
        nrst = 1;
        step();

        slv_mem[32'h0080_0D90] = 32'hDEAD_BEEF;
        ref_mem[32'h0080_0D90] = 32'hDEAD_BEEF;
        xact(1, 0, 32'h0080_0D90, 32'h0, 3);
        xact(0, 1, 32'h0000_0300, 32'hCAFE_F00D, 3);

        ar_dly = 2; r_dly = 3;
        foreach (b2b[i]) xact(1, 0, b2b[i], 32'h0, -1);
        ar_dly = 0; r_dly = 0;

        aw_dly = 0; w_dly = 2; b_dly = 1;
        xact(0, 1, 32'h0000_1000, 32'h1234_5678, -1);
        aw_dly = 0; w_dly = 0; b_dly = 0;
        xact(1, 0, 32'h0000_1000, 32'h0, 3);

        xact(1, 1, 32'h0000_0020, 32'h5555_AAAA, 3);

        r_dly = 60;
        n_ar = 0;
        read = 1; addr = 32'h0000_0444;
        cyc = 0;
        do begin step(); cyc++; end while (!rready && cyc < 20);
        chk("reach_rdata", rready, 1);
        read = 0; nrst = 0;
        step();
        chk("midrst_valids", {ready, arvalid, awvalid, wvalid, bready, rready}, 0);
        chk("midrst_load", load, 0);
        nrst = 1; r_dly = 0;
        step();
        xact(1, 0, 32'h0000_0444, 32'h0, 3);

`ifdef AXI_CTRL_ERR_EN
        r_resp_val = 2'b10;
        xact(1, 0, 32'h0000_0448, 32'h0, 3);
        r_resp_val = 2'b00;
        b_resp_val = 2'b11;
        xact(0, 1, 32'h0000_044C, 32'h0BAD_0BAD, 3);
        b_resp_val = 2'b00;
`endif

        for (int k = 0; k < 30; k++) begin
            bit rd, wr;
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            xact(rd, wr, 32'h0000_0100 + 32'($urandom_range(0, 3)) * 4, $urandom, -1);
        end

        chk("protocol", proto_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
